// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
//   F3_*          funct3 encodings accepted by the unit
//   state_t       controller state encoding
//   lsu_req_t     request payload held for the duration of one access
//   is_split()    access straddles a word boundary and needs two word accesses
//   is_illegal()  funct3/direction combination that is rejected without a memory access
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_ACC0_ENC = 2'd1;
    localparam logic [1:0] ST_ACC1_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ACC0 = ST_ACC0_ENC,
        ST_ACC1 = ST_ACC1_ENC,
        ST_RESP = ST_RESP_ENC
    } state_t;

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [1:0]        k;
        logic [DATA_W-1:0] wdata;
    } lsu_req_t;

    // Halfwords only straddle at offset 3; words at any nonzero offset.
    function automatic logic is_split(input logic [2:0] funct3, input logic [1:0] k);
        logic split;
        split = 1'b0;
        case (funct3)
            F3_H, F3_HU: split = (k == 2'd3);
            F3_W:        split = (k != 2'd0);
            default:     split = 1'b0;
        endcase
        return split;
    endfunction

    // Unsigned variants exist only for loads.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        bad = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the execute-side request/response and the data_memory port.
//   slave  : view of the load/store unit (takes requests, drives memory)
//   master : view of the environment (issues requests, supplies mem_q)
interface lsu_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;
    logic              mem_wren;
    logic [31:0]       mem_q;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_address, mem_byteena, mem_data, mem_wren
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_address, mem_byteena, mem_data, mem_wren
    );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational lane steering for one load/store access.
//   funct3, k       access size/sign and byte offset within the low word
//   wdata           LSB-aligned store data
//   lo, hi          low and high memory words as seen by the load
//   be_lo/be_hi     byte enables for the low/high word access
//   data_lo/data_hi lane-shifted store data for the low/high word access
//   rdata           extracted and extended load data
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  k,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] data_lo,
    output logic [31:0] data_hi,
    output logic [31:0] rdata
);

    logic [3:0]  base;
    logic [7:0]  mask;
    logic [5:0]  shamt;
    logic [63:0] wide_w;
    logic [31:0] wide_r;

    // A size mask shifted across an 8-lane window: the upper nibble is what spills into the next word.
    always_comb begin
        base = 4'b0001;
        case (funct3[1:0])
            2'b01:   base = 4'b0011;
            2'b10:   base = 4'b1111;
            default: base = 4'b0001;
        endcase
        shamt   = {k, 3'b000};
        mask    = {4'b0000, base} << k;
        be_lo   = mask[3:0];
        be_hi   = mask[7:4];
        wide_w  = {32'd0, wdata} << shamt;
        data_lo = wide_w[31:0];
        data_hi = wide_w[63:32];
    end

    // Load extract: shift the 64-bit {hi,lo} window down by the byte offset, then extend.
    always_comb begin
        wide_r = 32'({hi, lo} >> shamt);
        rdata  = '0;
        case (funct3)
            F3_B:    rdata = {{24{wide_r[7]}}, wide_r[7:0]};
            F3_BU:   rdata = {24'd0, wide_r[7:0]};
            F3_H:    rdata = {{16{wide_r[15]}}, wide_r[15:0]};
            F3_HU:   rdata = {16'd0, wide_r[15:0]};
            F3_W:    rdata = wide_r;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator in front of data_memory.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : req_* / rsp_* handshake with the execute stage and the
//                  mem_* word port (mem_q valid the cycle after mem_address)
// One request in flight; misaligned accesses become two word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
)(
    input  logic clock,
    input  logic reset,
    lsu_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    lsu_req_t          req_q;
    logic [ADDR_W-1:0] word_q;
    logic              err_q;
    logic [31:0]       lo_buf;

    logic              accept;
    logic              split;
    logic              wren_raw;
    logic              ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteena;
    logic [31:0]       mem_data;

    logic [3:0]        be_lo;
    logic [3:0]        be_hi;
    logic [31:0]       data_lo;
    logic [31:0]       data_hi;
    logic [31:0]       lane_lo;
    logic [31:0]       lane_rdata;

    // Byte address bits above the data_memory range are don't-care.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    assign accept = bus.req_valid && (state == ST_IDLE);
    assign split  = is_split(req_q.funct3, req_q.k);

    // A split load sees the low word in lo_buf and the high word live on mem_q.
    assign lane_lo = split ? lo_buf : bus.mem_q;

    lsu_byte_lane u_lane (
        .funct3  (req_q.funct3),
        .k       (req_q.k),
        .wdata   (req_q.wdata),
        .lo      (lane_lo),
        .hi      (bus.mem_q),
        .be_lo   (be_lo),
        .be_hi   (be_hi),
        .data_lo (data_lo),
        .data_hi (data_hi),
        .rdata   (lane_rdata)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture on acceptance and low-word buffering during the second access.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_q  <= '0;
            word_q <= '0;
            err_q  <= 1'b0;
            lo_buf <= '0;
        end else begin
            if (accept) begin
                req_q.we     <= bus.req_we;
                req_q.funct3 <= bus.req_funct3;
                req_q.k      <= bus.req_addr[1:0];
                req_q.wdata  <= bus.req_wdata;
                word_q       <= bus.req_addr[ADDR_W+1:2];
                err_q        <= is_illegal(bus.req_we, bus.req_funct3);
            end
            if (state == ST_ACC1) begin
                lo_buf <= bus.mem_q;
            end
        end
    end

    // Next-state and outputs; memory outputs depend only on registered state.
    always_comb begin
        state_nxt   = state;
        ready       = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        mem_address = '0;
        mem_byteena = '0;
        mem_data    = '0;
        wren_raw    = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = is_illegal(bus.req_we, bus.req_funct3) ? ST_RESP : ST_ACC0;
                end
            end
            ST_ACC0: begin
                mem_address = word_q;
                mem_byteena = be_lo;
                mem_data    = data_lo;
                wren_raw    = req_q.we;
                state_nxt   = split ? ST_ACC1 : ST_RESP;
            end
            ST_ACC1: begin
                mem_address = ADDR_W'(word_q + 1'b1);
                mem_byteena = be_hi;
                mem_data    = data_hi;
                wren_raw    = req_q.we;
                state_nxt   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || req_q.we) ? '0 : lane_rdata;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_err     = rsp_err;
    assign bus.rsp_rdata   = rsp_rdata;
    assign bus.mem_address = mem_address;
    assign bus.mem_byteena = mem_byteena;
    assign bus.mem_data    = mem_data;
    // Reset blocks a write even in the middle of an access.
    assign bus.mem_wren    = wren_raw && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 1-cycle data_memory model
// and a byte-addressed reference memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned NBYTES = 4 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(ADDR_W)) bus ();

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // data_memory model: registered address, read data one cycle later.
    logic [31:0]       mem [1024];
    logic              init_mem = 1'b0;
    logic              bd_we    = 1'b0;
    logic [ADDR_W-1:0] bd_addr  = '0;
    logic [31:0]       bd_data  = '0;
    int                wren_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus.mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteena[b]) mem[bus.mem_address][8*b +: 8] <= bus.mem_data[8*b +: 8];
        end
        if (bus.mem_wren) wren_cnt <= wren_cnt + 1;
        bus.mem_q <= mem[bus.mem_address];
    end

    // Reference: flat byte memory, wrapping at the end of the address space.
    logic [7:0] ref_mem [NBYTES];

    int n_cmp  = 0;
    int n_fail = 0;

    logic        got;
    int          lat;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] s_addr  [8];
    logic [3:0]  s_be    [8];
    logic [31:0] s_data  [8];
    logic        s_wren  [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_illegal(input logic we, input logic [2:0] f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        return we && f3[2];
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[4*w + i];
        return v;
    endfunction

    // Expected outcome of one request; stores also update the reference memory.
    task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] e_rdata,
                              output logic e_err, output int e_lat);
        int a;
        int n;
        logic [31:0] v;
        a       = int'(addr[ADDR_W+1:0]);
        n       = size_of(f3);
        e_rdata = '0;
        e_err   = ref_illegal(we, f3);
        if (e_err) begin
            e_lat = 1;
        end else begin
            e_lat = ((a % 4) + n > 4) ? 3 : 2;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[(a + i) % NBYTES] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) % NBYTES];
                if (n == 1) e_rdata = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                else if (n == 2) e_rdata = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                else e_rdata = v;
            end
        end
    endtask

    task automatic bd_write(input int w, input logic [31:0] d);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = ADDR_W'(w);
        bd_data = d;
        @(posedge clk);
        #1 bd_we = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[4*w + i] = d[8*i +: 8];
    endtask

    // Issue one request, hold garbage on req_* while busy, and record the response.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(negedge clk);
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        chk("rsp_quiet", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 6 && !got; c++) begin
            @(negedge clk);
            s_addr[c] = 32'(bus.mem_address);
            s_be[c]   = bus.mem_byteena;
            s_data[c] = bus.mem_data;
            s_wren[c] = bus.mem_wren;
            if (bus.rsp_valid) begin
                got     = 1'b1;
                lat     = c;
                r_rdata = bus.rsp_rdata;
                r_err   = bus.rsp_err;
            end
        end
        bus.req_valid = 1'b0;
        chk("rsp_seen", 32'(got), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        ref_access(we, f3, addr, wd, e_rdata, e_err, e_lat);
        run_req(we, f3, addr, wd);
        chk({tag, "_err"},   32'(r_err), 32'(e_err));
        chk({tag, "_rdata"}, r_rdata, e_rdata);
        chk({tag, "_lat"},   32'(lat), 32'(e_lat));
    endtask

    initial begin
        logic [2:0]  f3_tab [8];
        logic [2:0]  f3;
        logic [31:0] addr;
        logic        we;
        int          wc;
        int          diffs;

        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b010, 3'b001, 3'b011};
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int w = 0; w < 1024; w++)
            for (int i = 0; i < 4; i++) ref_mem[4*w + i] = init_word(w)[8*i +: 8];

        // Reset with memory preload.
        rst      = 1'b1;
        init_mem = 1'b1;
        @(posedge clk);
        #1 init_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",   32'(bus.req_ready), 32'd1);
        chk("rst_valid",   32'(bus.rsp_valid), 32'd0);
        chk("rst_err",     32'(bus.rsp_err), 32'd0);
        chk("rst_rdata",   bus.rsp_rdata, 32'd0);
        chk("rst_wren",    32'(bus.mem_wren), 32'd0);
        chk("rst_byteena", 32'(bus.mem_byteena), 32'd0);
        chk("rst_address", 32'(bus.mem_address), 32'd0);
        chk("rst_data",    bus.mem_data, 32'd0);

        // Aligned word store.
        do_op("sw_aligned", 1'b1, F3_W, 32'h0000_0010, 32'hDEADBEEF);
        chk("sw_acc0_addr", s_addr[1], 32'd4);
        chk("sw_acc0_be",   32'(s_be[1]), 32'hF);
        chk("sw_acc0_wren", 32'(s_wren[1]), 32'd1);
        chk("sw_acc0_data", s_data[1], 32'hDEADBEEF);

        // Sub-word loads with sign/zero extension.
        bd_write(4, 32'h80FF7F01);
        do_op("lb_13",  1'b0, F3_B,  32'h13, 32'd0);
        chk("lb_13_const", r_rdata, 32'hFFFFFF80);
        do_op("lbu_13", 1'b0, F3_BU, 32'h13, 32'd0);
        chk("lbu_13_const", r_rdata, 32'h00000080);
        do_op("lh_12",  1'b0, F3_H,  32'h12, 32'd0);
        chk("lh_12_const", r_rdata, 32'hFFFF80FF);

        // Split word store then split load.
        do_op("sw_split", 1'b1, F3_W, 32'h0E, 32'hAABBCCDD);
        chk("sws_acc0_addr", s_addr[1], 32'd3);
        chk("sws_acc0_be",   32'(s_be[1]), 32'b1100);
        chk("sws_acc0_data", s_data[1], 32'hCCDD0000);
        chk("sws_acc1_addr", s_addr[2], 32'd4);
        chk("sws_acc1_be",   32'(s_be[2]), 32'b0011);
        chk("sws_acc1_data", s_data[2], 32'h0000AABB);
        chk("sws_acc1_wren", 32'(s_wren[2]), 32'd1);
        do_op("lw_split", 1'b0, F3_W, 32'h0E, 32'd0);
        chk("lw_split_const", r_rdata, 32'hAABBCCDD);

        // Halfword straddling the top of memory wraps to word 0.
        bd_write(1023, 32'h12345678);
        bd_write(0, 32'hABCDEF80);
        do_op("lh_wrap", 1'b0, F3_H, 32'h0000_0FFF, 32'd0);
        chk("lh_wrap_acc1_addr", s_addr[2], 32'd0);
        chk("lh_wrap_const", r_rdata, 32'hFFFF8012);

        // Illegal funct3 and unsigned store: no memory write.
        wc = wren_cnt;
        do_op("illegal_011", 1'b1, 3'b011, 32'h20, 32'h55555555);
        chk("illegal_011_const_err", 32'(r_err), 32'd1);
        do_op("illegal_sbu", 1'b1, F3_BU, 32'h21, 32'h66666666);
        @(negedge clk);
        chk("illegal_no_wren", 32'(wren_cnt), 32'(wc));

        // Reset during the second half of a split store.
        ref_mem[14] = 8'h44;
        ref_mem[15] = 8'h33;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h0E;
        bus.req_wdata  = 32'h11223344;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_wren", 32'(bus.mem_wren), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_word4", mem[4], ref_word(4));
        chk("rst_mid_word3", mem[3], ref_word(3));

        // Randomized mix of loads and stores, including wrap-around addresses.
        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom);
            f3   = f3_tab[$urandom_range(0, 7)];
            addr = $urandom;
            if ($urandom_range(0, 3) == 0)
                addr[ADDR_W+1:0] = 12'(NBYTES - $urandom_range(1, 8));
            else
                addr[ADDR_W+1:0] = 12'($urandom_range(0, 47));
            do_op("rand", we, f3, addr, $urandom);
        end

        @(negedge clk);
        diffs = 0;
        for (int w = 0; w < 1024; w++) if (mem[w] !== ref_word(w)) diffs++;
        chk("final_mem_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
